// File: rtl/tinysoc_pkg.sv
// -----------------------------------------------------------------------------
// tinysoc_pkg
// Shared definitions for the tiny SoC: the instruction-RAM loader state
// encoding and the byte / instruction-word widths shared with the
// instruction RAM.
//
// Optional feature macro: LOADER_CHECKSUM_EN adds the CSUM state.
// -----------------------------------------------------------------------------
package tinysoc_pkg;

  // Width of one stream byte.
  localparam int BYTE_W  = 8;
  // Width of one instruction word; also the instruction RAM data width.
  localparam int IWORD_W = 16;

  // Loader states. CSUM exists only when the trailing checksum byte is used.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM    = 3'd5,
`endif
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

endpackage : tinysoc_pkg

// File: rtl/i_ram_loader.sv
// -----------------------------------------------------------------------------
// i_ram_loader
// Byte-stream program loader for the instruction RAM write port. After a
// start pulse it reads a big-endian 16-bit word count N, then N big-endian
// 16-bit words, and writes them to RAM addresses 0..N-1. The CPU is held in
// reset while a load is in progress.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : one trailing checksum byte follows the data; the 8-bit sum of
//               all data bytes plus that byte must be 0x00, otherwise ERR.
//   undefined : the stream ends after the last data byte.
//
// Parameters
//   ADDR_WIDTH  instruction RAM address width (capacity 2^ADDR_WIDTH words)
//   DATA_WIDTH  RAM word width, fixed at 16 (two bytes per word)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a load (from IDLE/DONE/ERR)
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  loader accepts a byte this cycle
//   w_addr     out  RAM write address
//   w_data     out  RAM write data
//   w_en       out  RAM write strobe, one cycle per word
//   busy       out  load in progress
//   done       out  sticky success flag (until next start)
//   error      out  sticky failure flag (until next start)
//   cpu_hold   out  CPU reset request, equal to busy
// -----------------------------------------------------------------------------
module i_ram_loader
  import tinysoc_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = IWORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  // Word counter is one bit wider than the address so that a full-capacity
  // image (N = 2^ADDR_WIDTH) can be counted without wrapping.
  localparam int CNT_W     = ADDR_WIDTH + 1;
  // Length comparisons are done one bit wider than the 16-bit length field
  // so that 2^16 (ADDR_WIDTH = 16) is representable.
  localparam int LEN_EXT_W = IWORD_W + 1;
  localparam logic [LEN_EXT_W-1:0] MAX_WORDS = LEN_EXT_W'(1) << ADDR_WIDTH;

  // State entered once the last data word (or an empty image) has been taken.
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL_STATE = ST_CSUM;
`else
  localparam loader_state_t TAIL_STATE = ST_DONE;
`endif

  loader_state_t           r_state;
  loader_state_t           w_next_state;

  logic [IWORD_W-1:0]      r_len;
  logic [BYTE_W-1:0]       r_data_hi;
  logic [CNT_W-1:0]        r_count;
  logic                    r_w_en;
  logic [ADDR_WIDTH-1:0]   r_w_addr;
  logic [DATA_WIDTH-1:0]   r_w_data;

  logic                    w_in_stream;
  logic                    w_accept;
  logic                    w_start_load;
  logic [IWORD_W-1:0]      w_len_full;
  logic                    w_len_too_long;
  logic                    w_len_zero;
  logic                    w_last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]       r_csum;
  logic [BYTE_W-1:0]       w_csum_next;
`endif

  // ---------------------------------------------------------------------------
  // Status decode: every byte-consuming state is also a busy state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_in_stream = (r_state == ST_LEN_HI)  || (r_state == ST_LEN_LO) ||
                  (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO);
`ifdef LOADER_CHECKSUM_EN
    w_in_stream = w_in_stream || (r_state == ST_CSUM);
`endif
  end

  assign w_accept     = rx_valid && w_in_stream;
  assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));

  // Full length is formed combinationally so the range decision can be made
  // on the same edge that accepts the low length byte.
  assign w_len_full     = {r_len[IWORD_W-1:BYTE_W], rx_data};
  assign w_len_too_long = {1'b0, w_len_full} > MAX_WORDS;
  assign w_len_zero     = (w_len_full == '0);
  // The word being accepted now is word r_count; it is the last when
  // r_count + 1 == N.
  assign w_last_word    = (LEN_EXT_W'(r_count) + LEN_EXT_W'(1)) == {1'b0, r_len};

`ifdef LOADER_CHECKSUM_EN
  assign w_csum_next = r_csum + rx_data;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next_state unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next_state = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_accept) w_next_state = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          if (w_len_too_long)  w_next_state = ST_ERR;
          else if (w_len_zero) w_next_state = TAIL_STATE;
          else                 w_next_state = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (w_accept) w_next_state = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        if (w_accept) w_next_state = w_last_word ? TAIL_STATE : ST_DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_accept) w_next_state = (w_csum_next == '0) ? ST_DONE : ST_ERR;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: length capture, byte assembly, word counter, write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_data_hi <= '0;
      r_count   <= '0;
      r_w_en    <= 1'b0;
      r_w_addr  <= '0;
      r_w_data  <= '0;
    end else begin
      // Write strobe is a single-cycle pulse.
      r_w_en <= 1'b0;
      if (w_start_load) begin
        r_count <= '0;
      end
      if (w_accept) begin
        case (r_state)
          ST_LEN_HI:  r_len[IWORD_W-1:BYTE_W] <= rx_data;
          ST_LEN_LO:  r_len[BYTE_W-1:0]       <= rx_data;
          ST_DATA_HI: r_data_hi               <= rx_data;
          ST_DATA_LO: begin
            r_w_en   <= 1'b1;
            r_w_addr <= r_count[ADDR_WIDTH-1:0];
            r_w_data <= {r_data_hi, rx_data};
            r_count  <= r_count + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of data bytes only; length bytes are excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_start_load) begin
      r_csum <= '0;
    end else if (w_accept && ((r_state == ST_DATA_HI) || (r_state == ST_DATA_LO))) begin
      r_csum <= w_csum_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rx_ready = w_in_stream;
  assign busy     = w_in_stream;
  assign cpu_hold = w_in_stream;
  assign done     = (r_state == ST_DONE);
  assign error    = (r_state == ST_ERR);
  assign w_en     = r_w_en;
  assign w_addr   = r_w_addr;
  assign w_data   = r_w_data;

endmodule : i_ram_loader

// File: tb/tb_i_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_i_ram_loader
// Self-checking bench for i_ram_loader built with ADDR_WIDTH = 4 (16 words)
// so the capacity boundary is cheap to reach. Honours LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i_ram_loader;

  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [15:0] word_q_t [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          done;
    logic          busy;
  } wr_t;

  typedef struct {
    logic [12*8-1:0] name;
    logic [0:7][7:0] b;
    int              nb;
    bit              rv;
    bit              exp_done;
    bit              exp_err;
    int              exp_nwr;
    logic [15:0]     w0;
    logic [15:0]     w1;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic          w_en;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  int n_checks = 0;
  int n_errors = 0;

  wr_t     act_wr [$];
  word_q_t exp_wr;

  i_ram_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_en     (w_en),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && w_en) act_wr.push_back('{addr: w_addr, data: w_data, done: done, busy: busy});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decode the image purely from the stream format.
  function automatic void model(input byte_q_t s, output bit m_done, output bit m_err);
    int n;
    logic [7:0] sum;
    exp_wr.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    n = int'({s[0], s[1]});
    if (n > CAP) begin
      m_err = 1'b1;
      return;
    end
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({s[2+2*i], s[3+2*i]});
      sum = 8'(sum + s[2+2*i] + s[3+2*i]);
    end
`ifdef LOADER_CHECKSUM_EN
    sum = 8'(sum + s[2+2*n]);
    if (sum == 8'h00) m_done = 1'b1;
    else              m_err  = 1'b1;
`else
    m_done = 1'b1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Offer bytes one at a time; a byte is consumed when valid && ready at the
  // rising edge (both sampled on the preceding falling edge).
  task automatic send(input byte_q_t s, input bit rv, output bit ok);
    int idx    = 0;
    int budget = 0;
    bit hs;
    while (idx < s.size() && budget < 4000) begin
      rx_data  = s[idx];
      rx_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
      budget++;
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    ok = (idx == s.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_w_en"},     32'(w_en),     32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
    check({tag, "_w_addr"},   32'(w_addr),   32'd0);
    check({tag, "_w_data"},   32'(w_data),   32'd0);
  endtask

  // Start a load, feed the stream (optionally pulsing start part-way through,
  // which must be ignored) and compare against exp_wr / e_done / e_err.
  task automatic run_and_check(input string name, input byte_q_t s, input bit rv,
                               input int mid_start, input bit e_done, input bit e_err);
    bit ok;
    bit ok2;
    byte_q_t part;
    act_wr.delete();
    pulse_start();
    check({name, "_busy_after_start"},  32'(busy),  32'd1);
    check({name, "_done_cleared"},      32'(done),  32'd0);
    check({name, "_error_cleared"},     32'(error), 32'd0);
    if (mid_start > 0) begin
      part = s[0:mid_start-1];
      send(part, rv, ok);
      pulse_start();
      part = s[mid_start:$];
      send(part, rv, ok2);
      ok = ok && ok2;
    end else begin
      send(s, rv, ok);
    end
    check({name, "_all_bytes_taken"}, 32'(ok), 32'd1);
    // Outcome is visible right after the edge accepting the final byte.
    check({name, "_done_at_last"},  32'(done),  32'(e_done));
    check({name, "_error_at_last"}, 32'(error), 32'(e_err));
    tick(3);
    check({name, "_done"},     32'(done),     32'(e_done));
    check({name, "_error"},    32'(error),    32'(e_err));
    check({name, "_busy"},     32'(busy),     32'd0);
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({name, "_n_writes"}, 32'(act_wr.size()), 32'(exp_wr.size()));
    if (act_wr.size() == exp_wr.size()) begin
      foreach (exp_wr[i]) begin
        check($sformatf("%s_addr%0d", name, i), 32'(act_wr[i].addr), 32'(i));
        check($sformatf("%s_data%0d", name, i), 32'(act_wr[i].data), 32'(exp_wr[i]));
      end
      if (exp_wr.size() > 0) begin
`ifdef LOADER_CHECKSUM_EN
        check({name, "_last_wr_done"}, 32'(act_wr[$].done), 32'd0);
        check({name, "_last_wr_busy"}, 32'(act_wr[$].busy), 32'd1);
`else
        check({name, "_last_wr_done"}, 32'(act_wr[$].done), 32'd1);
        check({name, "_last_wr_busy"}, 32'(act_wr[$].busy), 32'd0);
`endif
      end
    end
  endtask

  function automatic vec_t mk(input logic [12*8-1:0] name, input logic [63:0] b, input int nb,
                              input bit rv, input bit d, input bit e, input int nwr,
                              input logic [15:0] w0, input logic [15:0] w1);
    vec_t v;
    v.name = name; v.b = b; v.nb = nb; v.rv = rv;
    v.exp_done = d; v.exp_err = e; v.exp_nwr = nwr; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  initial begin
    vec_t    tbl [$];
    byte_q_t s;
    bit      m_done;
    bit      m_err;
    logic [7:0] sum;
    int      n;
    int      ck;

`ifdef LOADER_CHECKSUM_EN
    ck = 1;
`else
    ck = 0;
`endif

    // name, bytes, count, random-valid, done, error, #writes, word0, word1
    tbl.push_back(mk("two_words",  64'h0002_1234_ABCD_4200, 6 + ck, 1'b0, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD));
    tbl.push_back(mk("one_word",   64'h0001_1234_BA00_0000, 4 + ck, 1'b0, 1'b1, 1'b0, 1, 16'h1234, 16'h0000));
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back(mk("bad_csum",   64'h0001_1234_BB00_0000, 5,      1'b0, 1'b0, 1'b1, 1, 16'h1234, 16'h0000));
`endif
    tbl.push_back(mk("len_17",     64'h0011_0000_0000_0000, 2,      1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("len_256",    64'h0100_0000_0000_0000, 2,      1'b0, 1'b0, 1'b1, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("len_0",      64'h0000_0000_0000_0000, 2 + ck, 1'b0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk("toggle",     64'h0001_55AA_0100_0000, 4 + ck, 1'b1, 1'b1, 1'b0, 1, 16'h55AA, 16'h0000));

    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    check_reset_outputs("idle");

    // Table-driven directed streams.
    foreach (tbl[t]) begin
      s.delete();
      for (int i = 0; i < tbl[t].nb; i++) s.push_back(tbl[t].b[i]);
      exp_wr.delete();
      if (tbl[t].exp_nwr > 0) exp_wr.push_back(tbl[t].w0);
      if (tbl[t].exp_nwr > 1) exp_wr.push_back(tbl[t].w1);
      run_and_check($sformatf("%0s", tbl[t].name), s, tbl[t].rv, 0,
                    tbl[t].exp_done, tbl[t].exp_err);
    end

    // Exact-capacity image: 16 words fill addresses 0..15.
    s = '{8'h00, 8'h10};
    sum = 8'h00;
    for (int i = 0; i < 2 * CAP; i++) begin
      s.push_back(8'(i * 37 + 5));
      sum = 8'(sum + 8'(i * 37 + 5));
    end
    if (ck == 1) s.push_back(8'(-sum));
    model(s, m_done, m_err);
    run_and_check("len_16", s, 1'b0, 0, m_done, m_err);
    check("len_16_model_writes", 32'(exp_wr.size()), 32'(CAP));

    // start while busy is ignored: pulse it after the DATA_HI byte.
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    if (ck == 1) s.push_back(8'h42);
    exp_wr = '{16'h1234, 16'hABCD};
    run_and_check("start_busy", s, 1'b0, 3, 1'b1, 1'b0);

    // Reset after the first DATA_HI byte of a 2-word load.
    act_wr.delete();
    pulse_start();
    s = '{8'h00, 8'h02, 8'h12};
    send(s, 1'b0, m_done);
    check("rst_mid_bytes_taken", 32'(m_done), 32'd1);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    check("rst_mid_no_writes", 32'(act_wr.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    if (ck == 1) s.push_back(8'h42);
    exp_wr = '{16'h1234, 16'hABCD};
    run_and_check("after_rst", s, 1'b1, 0, 1'b1, 1'b0);

    // Randomised images against the reference model.
    for (int r = 0; r < 20; r++) begin
      s.delete();
      n = (r < 4) ? CAP - 1 + r : $urandom_range(0, CAP + 2);
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n <= CAP) begin
        sum = 8'h00;
        for (int i = 0; i < 2 * n; i++) begin
          s.push_back(8'($urandom));
          sum = 8'(sum + s[$]);
        end
        if (ck == 1) begin
          if ($urandom_range(0, 3) == 0) s.push_back(8'(-sum + 8'($urandom_range(1, 255))));
          else                           s.push_back(8'(-sum));
        end
      end
      model(s, m_done, m_err);
      run_and_check($sformatf("rand%0d", r), s, 1'b1, 0, m_done, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_i_ram_loader

// File: doc/i_ram_loader.md
# i_ram_loader

Byte-stream program loader that drives the write port of the instruction RAM. Sits between the UART receiver and the instruction RAM. On a start pulse it parses a length-prefixed image from a valid/ready byte stream and assembles big-endian 16-bit words. It writes those words to consecutive RAM addresses from 0 and holds the CPU in reset until the load completes.

## Interface
- ADDR_WIDTH, 12, instruction RAM address width; word capacity is 2^ADDR_WIDTH
- DATA_WIDTH, 16, RAM word width; fixed at 16 (two bytes per word)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts the byte; a transfer happens when rx_valid && rx_ready
- w_addr  out  ADDR_WIDTH  RAM write address
- w_data  out  16  RAM write data
- w_en  out  1  RAM write strobe, one cycle per word
- busy  out  1  load in progress
- done  out  1  sticky success flag
- error  out  1  sticky failure flag
- cpu_hold  out  1  high while busy; drives the CPU reset request

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM (only with the macro), DONE, ERR.
- IDLE/DONE/ERR + start: go to LEN_HI; clear done, error, word counter and checksum.
- start in any other state: ignored.
- LEN_HI/LEN_LO: latch the 16-bit word count N, high byte first.
- On LEN_LO accept:
  - N > 2^ADDR_WIDTH: go to ERR.
  - N = 0: go to CSUM (with macro) or DONE (without).
  - otherwise: go to DATA_HI.
- DATA_HI: latch the high byte. DATA_LO: on accept, register w_data = {hi, lo}, w_addr = counter, w_en = 1, then increment the counter.
- After word N-1 is written: go to CSUM (with macro) or DONE (without); else go back to DATA_HI.
- rx_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM; it is 0 otherwise.
- The byte after a write is accepted without a stall.
- busy = cpu_hold = 1 in every state except IDLE, DONE and ERR.
- done = 1 in DONE only; error = 1 in ERR only.
- Counter is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH fills the RAM exactly. No wrap-around.

## Timing
- Reset values: state IDLE; rx_ready, w_en, busy, cpu_hold, done, error = 0; w_addr = 0; w_data = 0.
- w_en rises on the clock edge that accepts the DATA_LO byte and stays high for exactly one cycle.
- w_addr and w_data are valid in the same cycle as w_en.
- Without the macro: done rises in the same cycle as the final w_en, and busy falls in that cycle.
- ERR on a length violation is entered on the edge that accepts LEN_LO.
- Throughput: one byte per cycle; a word needs at least 2 cycles.
- rx_valid without rx_ready: the byte is not consumed, and the loader does not sample rx_data.
- Reset mid-load: immediate return to IDLE with w_en = 0. The partial image in RAM is not cleared.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The CSUM state is present.
  - An 8-bit accumulator sums every DATA byte modulo 256; the length bytes are excluded.
  - The byte accepted in CSUM is added to the accumulator. If the result is 0x00, go to DONE; otherwise go to ERR.
  - The transition occurs on the edge that accepts the checksum byte.
- LOADER_CHECKSUM_EN undefined:
  - No CSUM state and no accumulator.
  - The stream ends after the last data byte.
  - error can only be caused by the length check.

## Structure
- Shared package tinysoc_pkg holds:
  - the loader state enum;
  - the byte-width constant (8);
  - the instruction-word width constant (16), shared with the instruction RAM.
- No sub-module: the byte assembly, counter and checksum are simple enough to stay inline.
- Instantiated next to the instruction RAM. w_addr, w_data and w_en connect to its write-address, write-data and write-enable ports.

## Test plan
- Without macro: start, then bytes 00 02 12 34 AB CD → writes 0x1234@0 and 0xABCD@1; done = 1; busy = 0; error = 0.
- With macro: stream 00 01 12 34 BA → done = 1. The same stream with checksum byte BB → error = 1 and no done.
- With ADDR_WIDTH = 4: length 00 11 (17) → ERR on LEN_LO accept, rx_ready = 0 afterwards, no w_en. Length 00 10 (16) → writes addresses 0..15, then done.
- rx_valid toggled randomly on stream 00 01 55 AA → exactly one write of 0x55AA@0; no bytes dropped or duplicated.
- rst_n asserted after the DATA_HI byte of a 2-word load → outputs return to reset values; a new start plus a full stream completes normally.
- Length 00 00 → done with no writes (with macro, after checksum byte 00). start pulsed while busy → ignored.
